// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: streams an instruction image into the CPU, lets it run, then checks its results against a golden image
//
// Ports:
//   clk_i, reset_n                                 clock, synchronous active-low reset
//   cfg_we_i, cfg_sel_i, cfg_addr_i, cfg_wdata_i   image write port (sel 0 = instruction, 1 = golden), honoured in IDLE/DONE
//   run_cycles_i                                   cycles the CPU runs between end of load and first check
//   stop_on_err_i                                  end the check at the first mismatch
//   start_i                                        start request, ignored while busy
//   value_i                                        CPU result, valid one cycle after address/lane are presented
//   cpu_reset_o, instr_o, data_or_reg_o            CPU reset, instruction byte stream, register-read select
//   address_o, vout_addr_o                         CPU register and lane being read back
//   busy_o, done_o, pass_o                         sequence status
//   err_cnt_o, first_err_idx_o, first_err_val_o    mismatch count and first mismatch details
module cpu_test_sequencer #(
    parameter int DW        = 8,
    parameter int N_INSTR   = 256,
    parameter int N_PAT     = 64,
    parameter int LANES     = 4,
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 8,
    parameter int RUN_W     = 16,
    localparam int CFG_W    = $clog2(N_INSTR > N_PAT ? N_INSTR : N_PAT),
    localparam int LW       = LANES > 1 ? $clog2(LANES) : 1,
    localparam int EW       = $clog2(N_PAT + 1),
    localparam int PW       = N_PAT > 1 ? $clog2(N_PAT) : 1
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              cfg_we_i,
    input  logic              cfg_sel_i,
    input  logic [CFG_W-1:0]  cfg_addr_i,
    input  logic [DW-1:0]     cfg_wdata_i,
    input  logic [RUN_W-1:0]  run_cycles_i,
    input  logic              stop_on_err_i,
    input  logic              start_i,
    input  logic [DW-1:0]     value_i,
    output logic              cpu_reset_o,
    output logic [DW-1:0]     instr_o,
    output logic              data_or_reg_o,
    output logic [ADDR_W-1:0] address_o,
    output logic [LW-1:0]     vout_addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [EW-1:0]     err_cnt_o,
    output logic [PW-1:0]     first_err_idx_o,
    output logic [DW-1:0]     first_err_val_o
);
    localparam int IW  = N_INSTR > 1 ? $clog2(N_INSTR) : 1;
    localparam int CW0 = RUN_W > IW ? RUN_W : IW;
    localparam int CW  = CW0 > EW ? CW0 : EW;

    typedef enum logic [2:0] {IDLE, CRST, LOAD, RUN, CHECK, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] err_q, err_d;
    logic [PW-1:0] fidx_q, fidx_d;
    logic [DW-1:0] fval_q, fval_d;
    logic          cpu_rst_q;
    logic [DW-1:0] instr_mem [N_INSTR];
    logic [DW-1:0] gold_mem [N_PAT];
    logic          cfg_ok, mismatch;
    logic [PW-1:0] pidx, cidx;

    assign cfg_ok = cfg_we_i && (state_q == IDLE || state_q == DONE);

    // Images have no reset so they survive a sequence abort.
    always_ff @(posedge clk_i) begin
        if (cfg_ok && !cfg_sel_i && 32'(cfg_addr_i) < N_INSTR)
            instr_mem[cfg_addr_i[IW-1:0]] <= cfg_wdata_i;
        if (cfg_ok && cfg_sel_i && 32'(cfg_addr_i) < N_PAT)
            gold_mem[cfg_addr_i[PW-1:0]] <= cfg_wdata_i;
    end

    // In CHECK, cnt_q is the pattern being presented and cnt_q-1 the one being compared.
    assign pidx     = (state_q == CHECK && 32'(cnt_q) < N_PAT) ? PW'(cnt_q) : '0;
    assign cidx     = PW'(cnt_q - 1'b1);
    assign mismatch = state_q == CHECK && cnt_q != '0 && value_i != gold_mem[cidx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fval_d  = fval_q;
        case (state_q)
            IDLE, DONE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = CRST;
                    err_d   = '0;
                    fidx_d  = '0;
                    fval_d  = '0;
                end
            end
            CRST: begin
                state_d = LOAD;
                cnt_d   = '0;
            end
            LOAD: if (cnt_q == CW'(N_INSTR - 1)) begin
                state_d = run_cycles_i == '0 ? CHECK : RUN;
                cnt_d   = '0;
            end
            RUN: if (cnt_q == CW'(run_cycles_i) - 1'b1) begin
                state_d = CHECK;
                cnt_d   = '0;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d  = err_q + 1'b1;
                    fidx_d = err_q == '0 ? cidx : fidx_q;
                    fval_d = err_q == '0 ? value_i : fval_q;
                end
                if (cnt_q == CW'(N_PAT) || (mismatch && stop_on_err_i))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_q     <= '0;
            fidx_q    <= '0;
            fval_q    <= '0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            fidx_q    <= fidx_d;
            fval_q    <= fval_d;
            cpu_rst_q <= state_d == CRST;
        end
    end

    assign cpu_reset_o     = cpu_rst_q;
    assign instr_o         = state_q == LOAD ? instr_mem[cnt_q[IW-1:0]] : '0;
    assign data_or_reg_o   = 1'b1;
    assign address_o       = ADDR_W'(BASE_ADDR) + ADDR_W'(32'(pidx) / LANES);
    assign vout_addr_o     = LW'(LANES - 1) - LW'(32'(pidx) % LANES);
    assign busy_o          = state_q != IDLE && state_q != DONE;
    assign done_o          = state_q == DONE;
    assign pass_o          = state_q == DONE && err_q == '0;
    assign err_cnt_o       = err_q;
    assign first_err_idx_o = fidx_q;
    assign first_err_val_o = fval_q;
endmodule

// File: doc/cpu_test_sequencer.md
# cpu_test_sequencer

Self-contained, synthesizable test sequencer for the CPU core. It streams a stored instruction image into the CPU's byte-serial instruction port, waits a programmable run time, then reads the CPU's result vector back lane by lane and checks each byte against a stored golden image. It reports pass/fail, an error count and the first mismatch. It sits beside the CPU on the FPGA/ASIC test wrapper, replacing the simulation-only stimulus/check flow, and is generalised in data width, image depth, lane count and check mode.

## Interface
- DW, 8, instruction/result data width
- N_INSTR, 256, instruction image depth in words
- N_PAT, 64, golden patterns checked
- LANES, 4, result lanes per CPU register (vout_addr range)
- ADDR_W, 5, CPU register address width
- BASE_ADDR, 8, first CPU register read back
- RUN_W, 16, width of run-cycle counter

- clk_i  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cfg_we_i  in  1  image write strobe
- cfg_sel_i  in  1  0 = instruction image, 1 = golden image
- cfg_addr_i  in  clog2(max(N_INSTR,N_PAT))  image write address
- cfg_wdata_i  in  DW  image write data
- run_cycles_i  in  RUN_W  cycles to wait between end of load and first check
- stop_on_err_i  in  1  1 = end check at first mismatch
- start_i  in  1  single-cycle start request
- value_i  in  DW  CPU result byte (value_o of CPU)
- cpu_reset_o  out  1  active-high reset to CPU
- instr_o  out  DW  instruction byte to CPU
- data_or_reg_o  out  1  CPU DataOrReg select, constant 1
- address_o  out  ADDR_W  CPU register address
- vout_addr_o  out  clog2(LANES)  CPU lane select
- busy_o  out  1  sequence in progress
- done_o  out  1  sequence complete, held until next start
- pass_o  out  1  valid when done_o; 1 = zero errors
- err_cnt_o  out  clog2(N_PAT+1)  mismatch count
- first_err_idx_o  out  clog2(N_PAT)  index of first mismatch
- first_err_val_o  out  DW  value_i at first mismatch

## Operation
- States: IDLE, CRST, LOAD, RUN, CHECK, DONE.
- Image writes are accepted only in IDLE/DONE; ignored otherwise. Out-of-range addresses are ignored. Images are not cleared by reset.
- IDLE/DONE + start_i: clear err_cnt, first_err_*, done_o, pass_o → CRST.
- CRST: exactly 1 cycle with cpu_reset_o=1 → LOAD.
- LOAD: k=0..N_INSTR-1, instr_o = instr_img[k], one word per cycle. After the last word, instr_o=0 → RUN.
- RUN: count run_cycles_i cycles (0 → straight to CHECK next cycle) → CHECK.
- CHECK, pattern idx: address_o = BASE_ADDR + idx/LANES, vout_addr_o = LANES-1 - (idx mod LANES), i.e. lanes in descending order, then the register increments. value_i is sampled one cycle after idx is presented; the check is pipelined, presenting idx+1 while comparing idx.
- Mismatch (value_i != golden[idx]): err_cnt++. On the first mismatch, capture idx and value_i.
- After the compare of idx N_PAT-1, or the first mismatch with stop_on_err_i=1 → DONE.
- DONE: done_o=1, pass_o=(err_cnt==0), busy_o=0. Outputs are held.
- start_i is ignored while busy_o=1.

## Timing
- Reset values: cpu_reset_o=1, instr_o=0, data_or_reg_o=1, address_o=BASE_ADDR, vout_addr_o=LANES-1, busy_o=0, done_o=0, pass_o=0, err_cnt_o=0, first_err_idx_o=0, first_err_val_o=0; state IDLE. After reset, cpu_reset_o drops to 0 in IDLE.
- start_i at cycle 0:
  - busy_o=1 and cpu_reset_o=1 at cycle 1.
  - instr_o=word k at cycle 2+k.
  - RUN occupies cycles 2+N_INSTR … 1+N_INSTR+run_cycles_i.
  - CHECK spans N_PAT+1 cycles.
  - done_o rises the cycle after the final compare.
- Total latency, full run: N_INSTR + run_cycles_i + N_PAT + 3 cycles from start_i to done_o.
- reset_n low in any state: the next edge returns all outputs to reset values; the sequence is abandoned.
- err_cnt cannot overflow: the counter is sized to N_PAT+1.

## Test plan
- Reset mid-LOAD (at k=100) → next cycle: busy_o=0, cpu_reset_o=1, instr_o=0, done_o=0.
- Images loaded, CPU model echoes golden, run_cycles=10, default parameters → done_o at cycle 333, pass_o=1, err_cnt=0; addresses step 8..23 with vout_addr 3,2,1,0 per address.
- Golden[5] corrupted, then golden[40] corrupted, stop_on_err=0 → err_cnt=2, first_err_idx=5, first_err_val=true value, pass_o=0, done_o after the full 64 checks.
- Same corruptions, stop_on_err=1 → done_o 1 cycle after the compare of idx 5, err_cnt=1.
- cfg write during RUN and start_i during CHECK → image unchanged, sequence unaffected; a rerun from DONE clears err_cnt and repeats the result.
- DW=16, N_INSTR=8, N_PAT=6, LANES=2, run_cycles=0 → address BASE..BASE+2, lanes 1,0 per address, 6 compares, done_o at cycle 17.
